// File: rtl/approx_eval_pkg.sv
// Shared constants and types for the approximate madd_i6_o4 evaluation harness.
package approx_eval_pkg;

  localparam int N_IN     = 6;   // circuit-under-test inputs
  localparam int N_OUT    = 4;   // circuit-under-test outputs
  localparam int N_VEC    = 64;  // exhaustive sweep length
  localparam int ERRSUM_W = 10;  // holds 64 * 15 = 960
  localparam int VCNT_W   = 7;   // holds 0..64
  localparam int SETTLE_W = 4;   // settle counter, SETTLE in 1..15

  // Operand fields inside the 6-bit vector: a = {in1,in0}, b = {in3,in2}, c = {in5,in4}.
  localparam int OPND_W = 2;
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 2;
  localparam int C_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  // Sweep statistics; cleared as one unit when a sweep starts.
  typedef struct packed {
    logic [N_OUT-1:0]    max_err;
    logic [ERRSUM_W-1:0] err_sum;
    logic [VCNT_W-1:0]   viol_cnt;
    logic [N_IN-1:0]     first_viol_vec;
    logic                first_viol_valid;
  } stats_t;

endpackage

// File: rtl/madd_exact_ref.sv
// Exact reference for the madd_i6_o4 family: result = a*b + c (0..12).
module madd_exact_ref
  import approx_eval_pkg::*;
(
  input  logic [N_IN-1:0]  vec_i,
  output logic [N_OUT-1:0] exact_o
);

  logic [N_OUT-1:0] a_w;
  logic [N_OUT-1:0] b_w;
  logic [N_OUT-1:0] c_w;

  // Widen each 2-bit operand so the product and sum are formed at result width.
  always_comb begin
    a_w     = N_OUT'(vec_i[A_LSB +: OPND_W]);
    b_w     = N_OUT'(vec_i[B_LSB +: OPND_W]);
    c_w     = N_OUT'(vec_i[C_LSB +: OPND_W]);
    exact_o = a_w * b_w + c_w;
  end

endmodule

// File: rtl/approx_madd_error_monitor.sv
// Exhaustive stimulus driver and error checker for an approximate 6-in/4-out
// multiply-add netlist: applies all 64 vectors, samples each result after a
// settle delay, and accumulates worst-case error, error sum and violations.
module approx_madd_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int unsigned ET     = 6,  // violation when |approx - exact| > ET
  parameter int unsigned SETTLE = 1   // hold cycles per vector, 1..15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_IN-1:0]     stim_o,
  input  logic [N_OUT-1:0]    resp_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_OUT-1:0]    max_err,
  output logic [ERRSUM_W-1:0] err_sum,
  output logic [VCNT_W-1:0]   viol_cnt,
  output logic [N_IN-1:0]     first_viol_vec,
  output logic                first_viol_valid
);

  localparam logic [N_OUT-1:0]    ET_W          = N_OUT'(ET);
  localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]     LAST_VEC      = N_IN'(N_VEC - 1);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  stats_t              stats_q, stats_d;

  logic [N_OUT-1:0] exact;
  logic [N_OUT:0]   diff;
  logic [N_OUT:0]   diff_neg;
  logic [N_OUT-1:0] abs_err;
  logic             viol;

  madd_exact_ref u_exact_ref (
    .vec_i   (vec_q),
    .exact_o (exact)
  );

  // Signed 5-bit difference folded to a 4-bit magnitude (0..15).
  always_comb begin
    diff     = {1'b0, resp_i} - {1'b0, exact};
    diff_neg = -diff;
    abs_err  = diff[N_OUT] ? diff_neg[N_OUT-1:0] : diff[N_OUT-1:0];
    viol     = (abs_err > ET_W);
  end

  // Sweep sequencing, statistics update and output decode.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    stats_d = stats_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          stats_d = '0;
          vec_d   = '0;
          cnt_d   = SETTLE_RELOAD;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        if (abs_err > stats_q.max_err) begin
          stats_d.max_err = abs_err;
        end
        stats_d.err_sum = stats_q.err_sum + ERRSUM_W'(abs_err);
        if (viol) begin
          stats_d.viol_cnt = stats_q.viol_cnt + VCNT_W'(1);
          if (!stats_q.first_viol_valid) begin
            stats_d.first_viol_vec   = vec_q;
            stats_d.first_viol_valid = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = SETTLE_RELOAD;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase

    stim_o           = vec_q;
    busy             = (state_q == APPLY) || (state_q == SAMPLE);
    done             = (state_q == DONE);
    pass             = (state_q == DONE) && (stats_q.max_err <= ET_W);
    max_err          = stats_q.max_err;
    err_sum          = stats_q.err_sum;
    viol_cnt         = stats_q.viol_cnt;
    first_viol_vec   = stats_q.first_viol_vec;
    first_viol_valid = stats_q.first_viol_valid;
  end

  // State and statistics registers; reset aborts any sweep and clears results.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      stats_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      stats_q <= stats_d;
    end
  end

endmodule

// File: tb/tb_approx_madd_error_monitor.sv
// Self-checking bench: two monitor instances (SETTLE=1 and SETTLE=3) drive a
// table-based circuit model, optionally registered, and every sweep result is
// compared with statistics computed directly from the table and a*b+c.
module tb_approx_madd_error_monitor;

  localparam int ET = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start1, start3;
  logic [5:0] stim1, stim3;
  logic [3:0] resp1, resp3, reg1, reg3;
  logic       busy1, done1, pass1, fvv1;
  logic       busy3, done3, pass3, fvv3;
  logic [3:0] maxe1, maxe3;
  logic [9:0] esum1, esum3;
  logic [6:0] vcnt1, vcnt3;
  logic [5:0] fvec1, fvec3;

  // Circuit-under-test model: a lookup table, optionally behind one register.
  logic [3:0] tab [64];
  bit         registered;

  assign resp1 = registered ? reg1 : tab[stim1];
  assign resp3 = registered ? reg3 : tab[stim3];
  always @(posedge clk) begin
    reg1 <= tab[stim1];
    reg3 <= tab[stim3];
  end

  approx_madd_error_monitor #(.ET(ET), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim_o(stim1), .resp_i(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .max_err(maxe1), .err_sum(esum1),
    .viol_cnt(vcnt1), .first_viol_vec(fvec1), .first_viol_valid(fvv1)
  );

  approx_madd_error_monitor #(.ET(ET), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim_o(stim3), .resp_i(resp3),
    .busy(busy3), .done(done3), .pass(pass3), .max_err(maxe3), .err_sum(esum3),
    .viol_cnt(vcnt3), .first_viol_vec(fvec3), .first_viol_valid(fvv3)
  );

  // View of the instance under test.
  int sel;  // 0: SETTLE=1, 1: SETTLE=3
  int o_busy, o_done, o_pass, o_max, o_sum, o_cnt, o_fvec, o_fvv, o_stim;
  always_comb begin
    if (sel == 0) begin
      o_busy = busy1; o_done = done1; o_pass = pass1; o_max = maxe1; o_sum = esum1;
      o_cnt  = vcnt1; o_fvec = fvec1; o_fvv = fvv1; o_stim = stim1;
    end else begin
      o_busy = busy3; o_done = done3; o_pass = pass3; o_max = maxe3; o_sum = esum3;
      o_cnt  = vcnt3; o_fvec = fvec3; o_fvv = fvv3; o_stim = stim3;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int exact_of(input int v);
    return (v % 4) * ((v / 4) % 4) + v / 16;
  endfunction

  task automatic fill_exact();
    for (int v = 0; v < 64; v++) tab[v] = 4'(exact_of(v));
  endtask

  task automatic fill_zero();
    for (int v = 0; v < 64; v++) tab[v] = 4'd0;
  endtask

  task automatic fill_random();
    for (int v = 0; v < 64; v++)
      tab[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(exact_of(v));
  endtask

  task automatic drive_start(input logic val);
    if (sel == 0) start1 = val;
    else          start3 = val;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stim"}, o_stim, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_max"},  o_max,  0);
    check({tag, "_sum"},  o_sum,  0);
    check({tag, "_cnt"},  o_cnt,  0);
    check({tag, "_fvec"}, o_fvec, 0);
    check({tag, "_fvv"},  o_fvv,  0);
  endtask

  // One sweep on the selected instance. poke_at >= 0 pulses start again at that
  // cycle of the sweep; abort_vec >= 0 pulls reset when that vector is applied.
  task automatic run_sweep(input string tag, input int poke_at, input int abort_vec);
    int settle, lat, cycles;
    int e_max, e_sum, e_cnt, e_fvec, e_fvv, d;
    bit finished;
    settle = (sel == 0) ? 1 : 3;
    lat    = 64 * (settle + 1);
    e_max = 0; e_sum = 0; e_cnt = 0; e_fvec = 0; e_fvv = 0;
    for (int v = 0; v < 64; v++) begin
      d = int'(tab[v]) - exact_of(v);
      if (d < 0) d = -d;
      if (d > e_max) e_max = d;
      e_sum += d;
      if (d > ET) begin
        e_cnt++;
        if (e_fvv == 0) begin e_fvv = 1; e_fvec = v; end
      end
    end

    drive_start(1'b1);
    @(posedge clk);  // accept edge
    @(negedge clk);
    drive_start(1'b0);
    check({tag, "_busy_rise"}, o_busy, 1);
    check({tag, "_done_clr"},  o_done, 0);
    check({tag, "_stim0"},     o_stim, 0);

    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (o_done != 0) begin
        finished = 1'b1;
      end else begin
        if (poke_at >= 0 && cycles == poke_at)     drive_start(1'b1);
        if (poke_at >= 0 && cycles == poke_at + 1) drive_start(1'b0);
        if (abort_vec >= 0 && o_stim == abort_vec) begin
          rst_n = 1'b0;
          #1;
          check_cleared({tag, "_abort"});
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
    drive_start(1'b0);

    check({tag, "_latency"}, cycles, lat);
    check({tag, "_busy"},    o_busy, 0);
    check({tag, "_stim63"},  o_stim, 63);
    check({tag, "_max"},     o_max,  e_max);
    check({tag, "_sum"},     o_sum,  e_sum);
    check({tag, "_cnt"},     o_cnt,  e_cnt);
    check({tag, "_fvv"},     o_fvv,  e_fvv);
    check({tag, "_fvec"},    o_fvec, e_fvec);
    check({tag, "_pass"},    o_pass, (e_max <= ET) ? 1 : 0);
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, o_done, 1);
    check({tag, "_hold_sum"},  o_sum,  e_sum);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; registered = 1'b0; sel = 0;
    fill_exact();
    repeat (2) @(negedge clk);
    #1;
    sel = 0; check_cleared("rst1");
    sel = 1; #1; check_cleared("rst3");
    rst_n = 1'b1;

    // Exact model looped back, start at cycle 5.
    sel = 0;
    repeat (5) @(negedge clk);
    run_sweep("exact", -1, -1);

    // Response tied to zero: known totals, restart from DONE.
    fill_zero();
    run_sweep("zero", -1, -1);
    check("zero_max_const",  o_max,  12);
    check("zero_sum_const",  o_sum,  240);
    check("zero_cnt_const",  o_cnt,  11);
    check("zero_fvec_const", o_fvec, 15);
    check("zero_pass_const", o_pass, 0);

    // Registered exact model on both settle settings.
    fill_exact();
    registered = 1'b1;
    sel = 1; run_sweep("reg_s3", -1, -1);
    sel = 0; run_sweep("reg_s1", -1, -1);
    registered = 1'b0;

    // Second start mid-sweep is ignored.
    fill_zero();
    run_sweep("poke", 40, -1);

    // Reset mid-sweep, then a clean sweep.
    fill_exact();
    run_sweep("abort", -1, 20);
    repeat (2) @(negedge clk);
    sel = 1; #1; check_cleared("abort_other");
    sel = 0;
    run_sweep("after_abort", -1, -1);

    // Randomized faulty tables on either instance, sometimes registered or poked.
    for (int it = 0; it < 6; it++) begin
      sel        = $urandom_range(0, 1);
      registered = 1'($urandom_range(0, 1));
      fill_random();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_sweep($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 100) : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
